// File: rtl/incr_pkg.sv
// Shared types and defaults for the incrementer sequencer.
// Optional saturation build: INCR_SEQ_SATURATE_EN.
package incr_pkg;

  localparam int WIDTH_D = 4;
  localparam int CNT_W_D = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/incr_sequencer_if.sv
// Request/result handshake bundle for incr_sequencer.
// master drives requests and accepts results; slave is the sequencer.
interface incr_sequencer_if
  import incr_pkg::*;
#(
  parameter int WIDTH = WIDTH_D,
  parameter int CNT_W = CNT_W_D
);

  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] load_val;
  logic             step_inc;
  logic [CNT_W-1:0] steps;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] result;
  logic             cout_seen;
  logic [CNT_W-1:0] wraps;

  modport master (
    output start_valid, load_val, step_inc, steps, res_ready,
    input  start_ready, res_valid, result, cout_seen, wraps
  );

  modport slave (
    input  start_valid, load_val, step_inc, steps, res_ready,
    output start_ready, res_valid, result, cout_seen, wraps
  );

endinterface

// File: rtl/incr_step.sv
// Combinational WIDTH-bit value plus 1-bit increment.
// Produces the wrapped sum and the carry-out.
module incr_step #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic             y,
  output logic [WIDTH-1:0] sum,
  output logic             c
);

  assign {c, sum} = {1'b0, a} + {{WIDTH{1'b0}}, y};

endmodule

// File: rtl/incr_sequencer.sv
// Applies an increment N times over a valid/ready request/result pair.
// Define INCR_SEQ_SATURATE_EN to clamp and stop on the first carry.
module incr_sequencer
  import incr_pkg::*;
#(
  parameter int WIDTH = WIDTH_D,
  parameter int CNT_W = CNT_W_D
) (
  input  logic             clk,
  input  logic             rst,
  incr_sequencer_if.slave  bus
);

  state_t           state;
  state_t           nxt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] sum;
  logic [CNT_W-1:0] rem;
  logic [CNT_W-1:0] wraps_q;
  logic             inc;
  logic             c;
  logic             cout_q;
  logic             accept;

  incr_step #(.WIDTH(WIDTH)) u_step (
    .a   (acc),
    .y   (inc),
    .sum (sum),
    .c   (c)
  );

  assign accept = (state == IDLE) && bus.start_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: begin
        if (bus.start_valid)
          nxt = (bus.steps == '0) ? DONE : RUN;
      end
      RUN: begin
        if (rem == CNT_W'(1)) nxt = DONE;
`ifdef INCR_SEQ_SATURATE_EN
        if (c) nxt = DONE;
`endif
      end
      DONE: begin
        if (bus.res_ready) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc     <= '0;
      rem     <= '0;
      inc     <= 1'b0;
      cout_q  <= 1'b0;
      wraps_q <= '0;
    end else if (accept) begin
      acc     <= bus.load_val;
      rem     <= bus.steps;
      inc     <= bus.step_inc;
      cout_q  <= 1'b0;
      wraps_q <= '0;
    end else if (state == RUN) begin
      acc <= sum;
      rem <= rem - CNT_W'(1);
      if (c) begin
        cout_q  <= 1'b1;
        wraps_q <= wraps_q + CNT_W'(1);
      end
`ifdef INCR_SEQ_SATURATE_EN
      // first carry clamps; it is always the first, so wraps is one
      if (c) begin
        acc     <= '1;
        wraps_q <= CNT_W'(1);
      end
`endif
    end
  end

  assign bus.start_ready = (state == IDLE);
  assign bus.res_valid   = (state == DONE);
  assign bus.result      = acc;
  assign bus.cout_seen   = cout_q;
  assign bus.wraps       = wraps_q;

endmodule

// File: tb/tb_incr_sequencer.sv
// Directed scoreboard bench for incr_sequencer.
// Expectations come from a behavioural model of the step loop.
module tb_incr_sequencer;

  typedef struct {
    logic [3:0] result;
    logic       cout;
    logic [3:0] wraps;
    int         lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t q[$];

  incr_sequencer_if #(.WIDTH(4), .CNT_W(4)) bus ();

  incr_sequencer #(.WIDTH(4), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(logic [3:0] v, logic i, logic [3:0] n);
    exp_t e;
    logic [4:0] s;
    e.result = v;
    e.cout   = 1'b0;
    e.wraps  = 4'd0;
    e.lat    = int'(n) + 1;
    for (int k = 1; k <= int'(n); k++) begin
      s = {1'b0, e.result} + {4'd0, i};
      e.result = s[3:0];
      if (s[4]) begin
        e.cout  = 1'b1;
        e.wraps = e.wraps + 4'd1;
`ifdef INCR_SEQ_SATURATE_EN
        e.result = 4'hF;
        e.lat    = k + 1;
        break;
`endif
      end
    end
    return e;
  endfunction

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run_req(input logic [3:0] v, input logic i,
                         input logic [3:0] n, input int hold);
    exp_t e;
    int   edges;
    q.push_back(model(v, i, n));
    check("start_ready_idle", 32'(bus.start_ready), 32'd1);
    bus.start_valid = 1'b1;
    bus.load_val    = v;
    bus.step_inc    = i;
    bus.steps       = n;
    @(posedge clk);
    #1;
    bus.start_valid = 1'b0;
    bus.load_val    = 4'd0;
    bus.step_inc    = 1'b0;
    bus.steps       = 4'd0;
    edges = 1;
    while (!bus.res_valid && edges < 40) begin
      @(posedge clk);
      #1;
      edges++;
    end
    e = q.pop_front();
    check("latency", 32'(edges), 32'(e.lat));
    check("res_valid", 32'(bus.res_valid), 32'd1);
    check("result", 32'(bus.result), 32'(e.result));
    check("cout_seen", 32'(bus.cout_seen), 32'(e.cout));
    check("wraps", 32'(bus.wraps), 32'(e.wraps));
    check("start_ready_done", 32'(bus.start_ready), 32'd0);
    for (int h = 0; h < hold; h++) begin
      bus.start_valid = 1'b1;
      bus.load_val    = ~v;
      bus.step_inc    = 1'b1;
      bus.steps       = 4'd2;
      @(posedge clk);
      #1;
      check("hold_valid", 32'(bus.res_valid), 32'd1);
      check("hold_result", 32'(bus.result), 32'(e.result));
      check("hold_wraps", 32'(bus.wraps), 32'(e.wraps));
    end
    bus.start_valid = 1'b0;
    bus.res_ready   = 1'b1;
    @(posedge clk);
    #1;
    bus.res_ready = 1'b0;
    check("res_valid_after", 32'(bus.res_valid), 32'd0);
    check("start_ready_after", 32'(bus.start_ready), 32'd1);
    check("result_kept", 32'(bus.result), 32'(e.result));
    check("cout_kept", 32'(bus.cout_seen), 32'(e.cout));
  endtask

  initial begin
    bus.start_valid = 1'b0;
    bus.load_val    = 4'd0;
    bus.step_inc    = 1'b0;
    bus.steps       = 4'd0;
    bus.res_ready   = 1'b0;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_start_ready", 32'(bus.start_ready), 32'd1);
    check("rst_res_valid", 32'(bus.res_valid), 32'd0);
    check("rst_result", 32'(bus.result), 32'd0);
    check("rst_cout", 32'(bus.cout_seen), 32'd0);
    check("rst_wraps", 32'(bus.wraps), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    run_req(4'b1110, 1'b1, 4'd1, 0);
    run_req(4'b1110, 1'b1, 4'd3, 0);
    run_req(4'b0101, 1'b1, 4'd0, 2);
    run_req(4'b0000, 1'b1, 4'd15, 5);
    run_req(4'b0011, 1'b0, 4'd15, 0);
    run_req(4'b1111, 1'b1, 4'd15, 1);

    // abort a run three steps in
    bus.start_valid = 1'b1;
    bus.load_val    = 4'd0;
    bus.step_inc    = 1'b1;
    bus.steps       = 4'd10;
    @(posedge clk);
    #1;
    bus.start_valid = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check("mid_run_acc", 32'(bus.result), 32'd3);
    check("mid_run_ready", 32'(bus.start_ready), 32'd0);
    rst = 1'b1;
    #1;
    check("abort_res_valid", 32'(bus.res_valid), 32'd0);
    check("abort_result", 32'(bus.result), 32'd0);
    check("abort_start_ready", 32'(bus.start_ready), 32'd1);
    check("abort_wraps", 32'(bus.wraps), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    run_req(4'b1010, 1'b1, 4'd4, 0);
    run_req(4'b0111, 1'b1, 4'd9, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
